// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: 4x4 matrix keypad scanner with column sync, debounce and key encoding.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid while a key stays held.
module keypad_scan_4x4 #(
  parameter int ROW_SETTLE_CYC   = 1000,
  parameter int DEBOUNCE_CYC     = 2000000,
  parameter int REPEAT_DELAY_CYC = 50000000,
  parameter int REPEAT_RATE_CYC  = 10000000
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       is_pressed,
  output logic [3:0] key_code,
  output logic       key_valid
);
  localparam int MAX_A = ROW_SETTLE_CYC > DEBOUNCE_CYC ? ROW_SETTLE_CYC : DEBOUNCE_CYC;
  localparam int MAX_B = REPEAT_DELAY_CYC > REPEAT_RATE_CYC ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int CW = $clog2(MAX_A > MAX_B ? MAX_A : MAX_B) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] SETTLE = CW'(ROW_SETTLE_CYC);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
  // nibble {row,col} holds the code for that key
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, HOLD} state_t;
  state_t state, state_d;
  logic [3:0] col_m, col_s, cand, cand_d, key_code_d;
  logic [1:0] r, r_d, c, c_d, c_low;
  logic [CW-1:0] settle, settle_d, cnt, cnt_d;
  logic is_pressed_d, key_valid_d, settled, hit, col_c;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY_CYC - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE_CYC - 1);
  logic [CW-1:0] rep, rep_d;
  logic armed, armed_d;
`endif
  assign settled = settle == SETTLE;
  assign hit = ~&col_s;
  assign col_c = col_s[c];
  assign c_low = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
  assign row_n = state == IDLE ? 4'b0000 : ~(4'b0001 << r);
  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      state <= IDLE;
      r <= 2'd0;
      c <= 2'd0;
      cand <= 4'h0;
      settle <= '0;
      cnt <= '0;
      key_code <= 4'h0;
      is_pressed <= 1'b0;
      key_valid <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep <= '0;
      armed <= 1'b0;
`endif
    end else begin
      col_m <= col_n;
      col_s <= col_m;
      state <= state_d;
      r <= r_d;
      c <= c_d;
      cand <= cand_d;
      settle <= settle_d;
      cnt <= cnt_d;
      key_code <= key_code_d;
      is_pressed <= is_pressed_d;
      key_valid <= key_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep <= rep_d;
      armed <= armed_d;
`endif
    end
  always_comb begin
    state_d = state;
    r_d = r;
    c_d = c;
    cand_d = cand;
    cnt_d = cnt;
    key_code_d = key_code;
    is_pressed_d = is_pressed;
    key_valid_d = 1'b0;
    settle_d = settled ? settle : settle + ONE;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d = rep;
    armed_d = armed;
`endif
    case (state)
      IDLE:
        if (settled && hit) begin
          state_d = SCAN;
          r_d = 2'd0;
          settle_d = '0;
        end
      SCAN:
        if (settled) begin
          if (hit) begin
            state_d = DEBOUNCE;
            c_d = c_low;
            cand_d = KEYMAP[{r, c_low, 2'b00} +: 4];
            cnt_d = '0;
          end else if (r != 2'd3) begin
            r_d = r + 2'd1;
            settle_d = '0;
          end else begin
            state_d = IDLE;
            settle_d = '0;
          end
        end
      DEBOUNCE:
        if (col_c) begin
          state_d = IDLE;
          settle_d = '0;
        end else if (cnt == DB_LAST) begin
          state_d = HOLD;
          key_code_d = cand;
          is_pressed_d = 1'b1;
          key_valid_d = 1'b1;
          cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d = '0;
          armed_d = 1'b0;
`endif
        end else cnt_d = cnt + ONE;
      HOLD: begin
        cnt_d = col_c ? cnt + ONE : '0;
        if (col_c && cnt == DB_LAST) begin
          state_d = IDLE;
          is_pressed_d = 1'b0;
          cnt_d = '0;
          settle_d = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d = col_c ? '0 : rep + ONE;
        armed_d = col_c ? 1'b0 : armed;
        if (!col_c && rep == (armed ? RATE_LAST : DELAY_LAST)) begin
          key_valid_d = 1'b1;
          rep_d = '0;
          armed_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb_keypad_scan_4x4: scoreboard bench; a keypad model drives col_n from row_n and held keys.
`timescale 1ns/1ps
module tb_keypad_scan_4x4;
  logic clk = 1'b0, sys_rst_n = 1'b0;
  logic [3:0] col_n, row_n, key_code, sb_exp;
  logic is_pressed, key_valid;
  logic [15:0] keys = '0;
  int checks = 0, errors = 0, cyc = 0;
  logic [3:0] exp_q[$];
  int vt[$];
  logic [3:0] kmap[16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scan_4x4 #(
    .ROW_SETTLE_CYC(4), .DEBOUNCE_CYC(16), .REPEAT_DELAY_CYC(64), .REPEAT_RATE_CYC(32)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .col_n(col_n), .row_n(row_n),
    .is_pressed(is_pressed), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk)
    if (sys_rst_n && key_valid) begin
      checks++;
      vt.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: key_code=%h with nothing expected", key_code);
      end else begin
        sb_exp = exp_q.pop_front();
        if (key_code !== sb_exp || is_pressed !== 1'b1) begin
          errors++;
          $display("FAIL scoreboard_code: got key_code=%h is_pressed=%b, expected %h/1", key_code, is_pressed, sb_exp);
        end
      end
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pressed(input logic lvl, input int max, input string name, output int n);
    n = 0;
    while (is_pressed !== lvl && n < max) begin
      tick(1);
      n++;
    end
    if (is_pressed !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: is_pressed not %b after %0d cycles", name, lvl, max);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(3);
    check("reset_row_n", row_n, 4'b0000);
    check("reset_key_code", key_code, 4'h0);
    check("reset_is_pressed", is_pressed, 1'b0);
    check("reset_key_valid", key_valid, 1'b0);
    sys_rst_n = 1'b1;
    tick(10);
    // clean press of '6' (row1/col2)
    exp_q.push_back(4'h6);
    keys[6] = 1'b1;
    wait_pressed(1'b1, 60, "press6_rise", n);
    check_range("press6_rise_latency", n, 1, 40);
    tick(100 - n);
    keys = '0;
    wait_pressed(1'b0, 40, "press6_fall", n);
    check_range("press6_fall_latency", n, 16, 20);
    check("press6_code_held", key_code, 4'h6);
    tick(20);
    // bouncing '1' must never be accepted
    for (int i = 0; i < 5; i++) begin
      keys[0] = 1'b1;
      tick(10);
      check("bounce_pressed", is_pressed, 1'b0);
      keys[0] = 1'b0;
      tick(3);
    end
    tick(40);
    check("bounce_idle_rows", row_n, 4'b0000);
    check("bounce_code_kept", key_code, 4'h6);
    // 'A' and '7' together: scan order picks 'A', then '7' after 'A' is released
    exp_q.push_back(4'hA);
    keys[3] = 1'b1;
    keys[8] = 1'b1;
    wait_pressed(1'b1, 60, "simul_rise", n);
    check("simul_code", key_code, 4'hA);
    tick(20);
    exp_q.push_back(4'h7);
    keys[3] = 1'b0;
    wait_pressed(1'b0, 40, "simul_release_a", n);
    wait_pressed(1'b1, 80, "simul_rescan", n);
    check("simul_rescan_code", key_code, 4'h7);
    keys = '0;
    wait_pressed(1'b0, 40, "simul_fall", n);
    tick(20);
    // reset in the middle of debouncing '5'
    keys[5] = 1'b1;
    n = 0;
    while (row_n !== 4'b1101 && n < 60) begin
      tick(1);
      n++;
    end
    check("rst_reach_row1", row_n, 4'b1101);
    tick(13);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_row_n", row_n, 4'b0000);
    check("rst_is_pressed", is_pressed, 1'b0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_code", key_code, 4'h0);
    tick(3);
    exp_q.push_back(4'h5);
    sys_rst_n = 1'b1;
    wait_pressed(1'b1, 60, "rst_reaccept", n);
    check("rst_reaccept_code", key_code, 4'h5);
    keys = '0;
    wait_pressed(1'b0, 40, "rst_fall", n);
    tick(20);
    // full map sweep
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(kmap[k]);
      keys[k] = 1'b1;
      wait_pressed(1'b1, 60, $sformatf("sweep_rise_%0d", k), n);
      check($sformatf("sweep_code_%0d", k), key_code, kmap[k]);
      tick(5);
      keys[k] = 1'b0;
      wait_pressed(1'b0, 40, $sformatf("sweep_fall_%0d", k), n);
      tick(10);
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    vt.delete();
    repeat (6) exp_q.push_back(4'h5);
    keys[5] = 1'b1;
    wait_pressed(1'b1, 60, "rep_rise", n);
    tick(200);
    keys = '0;
    wait_pressed(1'b0, 40, "rep_fall", n);
    tick(60);
    check("rep_count", vt.size(), 6);
    if (vt.size() == 6)
      for (int i = 1; i < 6; i++) check($sformatf("rep_gap_%0d", i), vt[i] - vt[0], 32 * (i + 1));
`endif
    tick(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scan_4x4.md
Name: keypad_scan_4x4

Overview:
Scans a 4x4 matrix keypad at 100 MHz. It drives the row lines active-low, synchronises and debounces the column lines, and encodes the first valid key into a 4-bit code. It sits directly upstream of the electronic-keyboard decoder and feeds it a level `is_pressed` and a held `key_code`:
- codes 1..7 select notes;
- codes A..C select the octave.

Parameters:
- ROW_SETTLE_CYC, 1000: clocks to wait after changing `row_n` before sampling the columns (10 us).
- DEBOUNCE_CYC, 2000000: consecutive stable clocks required to accept a press or a release (20 ms).
- REPEAT_DELAY_CYC, 50000000: hold time before the first auto-repeat (optional feature only).
- REPEAT_RATE_CYC, 10000000: period between auto-repeats (optional feature only).

Ports:
- clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous, active-low reset.
- col_n  in  4  keypad columns; pulled up externally; low = connected to the driven row.
- row_n  out  4  keypad rows; 0 = driven.
- is_pressed  out  1  debounced key-held level.
- key_code  out  4  code of the last accepted key; holds after release.
- key_valid  out  1  one-clock pulse on each accepted press.

Behaviour:
- Reset is asynchronous on `sys_rst_n`, active-low, clock `clk`. Reset values:
  - `row_n` = 4'b0000;
  - `key_code` = 4'h0, `is_pressed` = 0, `key_valid` = 0;
  - state = IDLE; all counters = 0.
  - Reset asserted mid-operation aborts immediately; no `key_valid` is produced.
- `col_n` passes through a 2-flop synchroniser, giving `col_s`. All decisions use `col_s`.
- Key map, index [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D (E = '*', F = '#')
- IDLE:
  - `row_n` = 0000.
  - Settle counter runs for ROW_SETTLE_CYC; then `col_s` is sampled every cycle.
  - Any bit low → SCAN with r = 0 and the settle counter cleared.
- SCAN:
  - `row_n` = ~(1<<r). Wait ROW_SETTLE_CYC, then sample.
  - If any `col_s` bit is low: latch r and c = lowest low column index; candidate = map[r][c]; → DEBOUNCE.
  - Else if r < 3: r++ and clear the settle counter.
  - Else (r = 3, nothing found, i.e. a glitch) → IDLE.
- DEBOUNCE:
  - `row_n` holds row r.
  - Counter increments while `col_s[c]` = 0; it saturates at DEBOUNCE_CYC-1.
  - `col_s[c]` = 1 before the count completes → IDLE, with no outputs changed.
  - Count complete:
    - `key_code` <= candidate and `is_pressed` <= 1;
    - `key_valid` = 1 for exactly one clock;
    - → HOLD.
- HOLD:
  - `row_n` holds row r.
  - Release counter increments while `col_s[c]` = 1 and clears whenever `col_s[c]` = 0.
  - On reaching DEBOUNCE_CYC: `is_pressed` <= 0 → IDLE.
  - `key_code` is unchanged.
- Simultaneous keys: the first hit in scan order (lowest row, then lowest column) wins. Other keys are ignored until the winning key is released. A second key pressed during HOLD is not reported.
- Latency, clean press to `key_valid`: at most 2 + ROW_SETTLE_CYC·(r+2) + DEBOUNCE_CYC + 4 clocks.
- Counter widths: $clog2 of the largest parameter plus 1. Unsigned compare; counters never wrap.
- `key_valid` and `is_pressed` are registered outputs with no combinational path from `col_n`.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HOLD, a repeat counter runs while the key is still down.
  - After REPEAT_DELAY_CYC it pulses `key_valid` once, then again every REPEAT_RATE_CYC.
  - The counter clears on entering HOLD and on any `col_s[c]` = 1 cycle.
- Undefined: exactly one `key_valid` per press; the REPEAT_* parameters are unused.

Test Plan (ROW_SETTLE_CYC = 4, DEBOUNCE_CYC = 16, REPEAT_DELAY_CYC = 64, REPEAT_RATE_CYC = 32):
- Clean press row1/col2, held 100 clocks then released → single `key_valid`; `key_code` = 4'h6; `is_pressed` rises within 40 clocks of the press; `is_pressed` falls 16–20 clocks after release; `key_code` stays 6.
- Bounce: row0/col0 toggled low 10 clocks, high 3 clocks, repeated 5 times, then released → no `key_valid`; `is_pressed` stays 0; FSM returns to IDLE.
- Simultaneous press row0/col3 ('A') and row2/col0 ('7') → `key_code` = 4'hA. With 'A' released and '7' still held, a new press is reported after the '7' re-scan: `key_code` = 4'h7.
- Reset asserted 8 clocks into DEBOUNCE → `row_n` = 0000, `is_pressed` = 0, `key_valid` never pulses; after release of reset with the key still held, the key is accepted normally.
- Map sweep over all 16 keys, each pressed then released → `key_code` sequence exactly 1,2,3,A,4,5,6,B,7,8,9,C,E,0,F,D.
- KEYPAD_AUTOREPEAT_EN, hold '5' for 200 clocks after acceptance → `key_valid` pulses at acceptance and at +64, +96, +128, +160, +192; none after release.
